regfile_writeback: RTL and testbench

Write-side initiator for the 32-entry register file. It accepts retired results from the memory/execute stage over a valid/ready handshake, buffers them in a small in-order queue, and drives the register file's `reg_write` / `write_register` / `write_data` inputs one write per cycle. It also answers two combinational forwarding lookups, so decode sees results that are still pending in the queue or in flight.

---
 rtl/regfile_wb_pkg.sv | 16 +
 rtl/wb_entry_fifo.sv | 77 +++++++
 rtl/regfile_writeback.sv | 133 +++++++++++++
 tb/tb_regfile_writeback.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int REG_ZERO = 0;

  // One pending register-file write: destination index and result value.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order circular buffer of pending writes, with every slot exposed oldest-first for lookups.
// Latency: a push is visible at the head on the cycle after the edge that wrote it.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
module wb_entry_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = regfile_wb_pkg::wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head_entry,
  output logic [CNT_W-1:0]       count,
  output entry_t [DEPTH-1:0]     age_entry,
  output logic   [DEPTH-1:0]     age_vld
);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && (count_q < CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  // Next-state for storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (do_pop) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  // Control state: pointers and count cleared on reset so all stored data is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; slots are only observed while marked valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Rotate storage into age order (index 0 = head/oldest) and mark occupied slots.
  always_comb begin
    age_entry = '0;
    age_vld   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem_q[head_q + PTR_W'(i)];
      age_vld[i]   = CNT_W'(i) < count_q;
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Queues retired results and issues one register-file write per cycle, with two forwarding lookups.
// Latency: push at edge N into an empty queue drives reg_write during N+1..N+2; the register file commits at N+2.
// Backpressure: in_ready = count < DEPTH from registered state only; wb_hold stalls pops, not the output stage.
module regfile_writeback #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int  DATA_W = regfile_wb_pkg::DATA_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_hold,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] lookup_reg_1,
  input  logic [ADDR_W-1:0] lookup_reg_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [CNT_W-1:0]  count,
  output logic              idle
);

  import regfile_wb_pkg::*;

  // Entry type sized by this instance's parameters rather than the package defaults.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               push_entry;
  entry_t               head_entry;
  entry_t [DEPTH-1:0]   age_entry;
  logic   [DEPTH-1:0]   age_vld;
  logic                 push_en;
  logic                 pop_en;

  logic                 reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]    write_register_q, write_register_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;

  // Writes to register 0 are accepted on the handshake but never enqueued.
  assign in_ready   = count < CNT_W'(DEPTH);
  assign push_en    = in_valid && in_ready && (in_rd != ADDR_W'(REG_ZERO));
  assign pop_en     = (count != '0) && !wb_hold;
  assign push_entry = '{rd: in_rd, data: in_data};

  wb_entry_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_en),
    .push_entry (push_entry),
    .pop        (pop_en),
    .head_entry (head_entry),
    .count      (count),
    .age_entry  (age_entry),
    .age_vld    (age_vld)
  );

  // Output stage: load the head on a pop, otherwise drop the enable and hold index/data.
  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (pop_en) begin
      reg_write_d      = 1'b1;
      write_register_d = head_entry.rd;
      write_data_d     = head_entry.data;
    end
  end

  // Output-stage registers; reset also suppresses any write the same edge would launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  // Youngest-match search: output stage is oldest, then queue head to tail so later matches override.
  function automatic logic [DATA_W:0] fwd_search(input logic [ADDR_W-1:0] idx);
    logic              hit;
    logic [DATA_W-1:0] val;
    hit = 1'b0;
    val = '0;
    if (reg_write_q && (write_register_q == idx)) begin
      hit = 1'b1;
      val = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i] && (age_entry[i].rd == idx)) begin
        hit = 1'b1;
        val = age_entry[i].data;
      end
    end
    if (idx == ADDR_W'(REG_ZERO)) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  // Forwarding port 1 lookup.
  always_comb begin
    {fwd_hit_1, fwd_data_1} = fwd_search(lookup_reg_1);
  end

  // Forwarding port 2 lookup.
  always_comb begin
    {fwd_hit_2, fwd_data_2} = fwd_search(lookup_reg_2);
  end

  assign reg_write      = reg_write_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign idle           = (count == '0) && !reg_write_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          wb_hold;
  logic          reg_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic [AW-1:0] lookup_reg_1, lookup_reg_2;
  logic          fwd_hit_1, fwd_hit_2;
  logic [DW-1:0] fwd_data_1, fwd_data_2;
  logic [CW-1:0] count;
  logic          idle;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_data        (in_data),
    .wb_hold        (wb_hold),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .lookup_reg_1   (lookup_reg_1),
    .lookup_reg_2   (lookup_reg_2),
    .fwd_hit_1      (fwd_hit_1),
    .fwd_hit_2      (fwd_hit_2),
    .fwd_data_1     (fwd_data_1),
    .fwd_data_2     (fwd_data_2),
    .count          (count),
    .idle           (idle)
  );

  // One clock of stimulus plus the state expected just after that edge.
  typedef struct {
    logic          vld;
    logic [AW-1:0] rd;
    logic [DW-1:0] dat;
    logic          hold;
    logic [AW-1:0] lk1;
    logic [AW-1:0] lk2;
    logic          e_rw;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;
    logic [CW-1:0] e_cnt;
    logic          e_rdy;
    logic          e_idle;
    logic          e_h1;
    logic [DW-1:0] e_d1;
    logic          e_h2;
    logic [DW-1:0] e_d2;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(
    input logic vld, input logic [AW-1:0] rd, input logic [DW-1:0] dat, input logic hold,
    input logic [AW-1:0] lk1, input logic [AW-1:0] lk2,
    input logic e_rw, input logic [AW-1:0] e_wr, input logic [DW-1:0] e_wd,
    input logic [CW-1:0] e_cnt, input logic e_rdy, input logic e_idle,
    input logic e_h1, input logic [DW-1:0] e_d1, input logic e_h2, input logic [DW-1:0] e_d2);
    vec_t v;
    v.vld = vld;   v.rd = rd;     v.dat = dat;     v.hold = hold;
    v.lk1 = lk1;   v.lk2 = lk2;
    v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_idle = e_idle;
    v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [AW-1:0] rd, input logic [DW-1:0] dat,
                       input logic hold, input logic [AW-1:0] lk1, input logic [AW-1:0] lk2);
    in_valid     = vld;
    in_rd        = rd;
    in_data      = dat;
    wb_hold      = hold;
    lookup_reg_1 = lk1;
    lookup_reg_2 = lk2;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);

    //           vld rd  data       hold lk1 lk2  rw wr  wd        cnt rdy idle h1 d1        h2 d2
    // Single write and its forwarding window.
    tbl.push_back(mk(1,  7, 'h1234,  0,   7,  0,   0,  0, 'h0,     1,  1,  0,   1, 'h1234,  0, 'h0));
    tbl.push_back(mk(0,  0, 'h0,     0,   7,  0,   1,  7, 'h1234,  0,  1,  0,   1, 'h1234,  0, 'h0));
    tbl.push_back(mk(0,  0, 'h0,     0,   7,  0,   0,  7, 'h1234,  0,  1,  1,   0, 'h0,     0, 'h0));
    // Register 0 is accepted but dropped.
    tbl.push_back(mk(1,  0, 'hFFFF,  0,   0,  7,   0,  7, 'h1234,  0,  1,  1,   0, 'h0,     0, 'h0));
    tbl.push_back(mk(0,  0, 'h0,     0,   0,  7,   0,  7, 'h1234,  0,  1,  1,   0, 'h0,     0, 'h0));
    // Fill under hold, same-register priority, fifth push refused.
    tbl.push_back(mk(1,  3, 'hA,     1,   3,  7,   0,  7, 'h1234,  1,  1,  0,   1, 'hA,     0, 'h0));
    tbl.push_back(mk(1,  3, 'hB,     1,   3,  7,   0,  7, 'h1234,  2,  1,  0,   1, 'hB,     0, 'h0));
    tbl.push_back(mk(1,  5, 'hC,     1,   3,  5,   0,  7, 'h1234,  3,  1,  0,   1, 'hB,     1, 'hC));
    tbl.push_back(mk(1,  6, 'hD,     1,   3,  6,   0,  7, 'h1234,  4,  0,  0,   1, 'hB,     1, 'hD));
    tbl.push_back(mk(1,  9, 'hE,     1,   3,  9,   0,  7, 'h1234,  4,  0,  0,   1, 'hB,     0, 'h0));
    // Release hold: in-order drain; queued 3/B beats output-stage 3/A.
    tbl.push_back(mk(0,  0, 'h0,     0,   3,  6,   1,  3, 'hA,     3,  1,  0,   1, 'hB,     1, 'hD));
    tbl.push_back(mk(0,  0, 'h0,     0,   3,  6,   1,  3, 'hB,     2,  1,  0,   1, 'hB,     1, 'hD));
    // Simultaneous push and pop at count 2.
    tbl.push_back(mk(1,  8, 'h88,    0,   3,  8,   1,  5, 'hC,     2,  1,  0,   0, 'h0,     1, 'h88));
    tbl.push_back(mk(1, 10, 'hAA,    0,   5,  6,   1,  6, 'hD,     2,  1,  0,   0, 'h0,     1, 'hD));
    tbl.push_back(mk(0,  0, 'h0,     0,   8, 10,   1,  8, 'h88,    1,  1,  0,   1, 'h88,    1, 'hAA));
    tbl.push_back(mk(0,  0, 'h0,     0,   8, 10,   1, 10, 'hAA,    0,  1,  0,   0, 'h0,     1, 'hAA));
    tbl.push_back(mk(0,  0, 'h0,     0,   8, 10,   0, 10, 'hAA,    0,  1,  1,   0, 'h0,     0, 'h0));
    // Hold raised while a write sits in the output stage: that write still completes.
    tbl.push_back(mk(1,  4, 'h44,    0,   4, 12,   0, 10, 'hAA,    1,  1,  0,   1, 'h44,    0, 'h0));
    tbl.push_back(mk(0,  0, 'h0,     0,   4, 12,   1,  4, 'h44,    0,  1,  0,   1, 'h44,    0, 'h0));
    tbl.push_back(mk(1, 12, 'hC0,    1,   4, 12,   0,  4, 'h44,    1,  1,  0,   0, 'h0,     1, 'hC0));
    tbl.push_back(mk(0,  0, 'h0,     0,   4, 12,   1, 12, 'hC0,    0,  1,  0,   0, 'h0,     1, 'hC0));
    tbl.push_back(mk(0,  0, 'h0,     0,   4, 12,   0, 12, 'hC0,    0,  1,  1,   0, 'h0,     0, 'h0));

    // Reset state.
    step_clk();
    step_clk();
    reset = 1'b0;
    chk("rst_reg_write", -1, DW'(reg_write), DW'(0));
    chk("rst_write_register", -1, DW'(write_register), DW'(0));
    chk("rst_write_data", -1, write_data, DW'(0));
    chk("rst_count", -1, DW'(count), DW'(0));
    chk("rst_in_ready", -1, DW'(in_ready), DW'(1));
    chk("rst_idle", -1, DW'(idle), DW'(1));
    chk("rst_fwd_hit_1", -1, DW'(fwd_hit_1), DW'(0));
    chk("rst_fwd_hit_2", -1, DW'(fwd_hit_2), DW'(0));

    // Table-driven sequence.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].rd, tbl[i].dat, tbl[i].hold, tbl[i].lk1, tbl[i].lk2);
      step_clk();
      chk("reg_write",      i, DW'(reg_write),      DW'(tbl[i].e_rw));
      chk("write_register", i, DW'(write_register), DW'(tbl[i].e_wr));
      chk("write_data",     i, write_data,          tbl[i].e_wd);
      chk("count",          i, DW'(count),          DW'(tbl[i].e_cnt));
      chk("in_ready",       i, DW'(in_ready),       DW'(tbl[i].e_rdy));
      chk("idle",           i, DW'(idle),           DW'(tbl[i].e_idle));
      chk("fwd_hit_1",      i, DW'(fwd_hit_1),      DW'(tbl[i].e_h1));
      chk("fwd_data_1",     i, fwd_data_1,          tbl[i].e_d1);
      chk("fwd_hit_2",      i, DW'(fwd_hit_2),      DW'(tbl[i].e_h2));
      chk("fwd_data_2",     i, fwd_data_2,          tbl[i].e_d2);
    end

    // Reset mid-drain: three held entries, then reset on the edge that would pop the first.
    drive(1'b1, 5'd1, 'h11, 1'b1, 5'd2, 5'd3);
    step_clk();
    drive(1'b1, 5'd2, 'h22, 1'b1, 5'd2, 5'd3);
    step_clk();
    drive(1'b1, 5'd3, 'h33, 1'b1, 5'd2, 5'd3);
    step_clk();
    chk("mid_count_before", 100, DW'(count), DW'(3));
    chk("mid_hit_before", 100, DW'(fwd_hit_2), DW'(1));
    drive(1'b0, '0, '0, 1'b0, 5'd2, 5'd3);
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    chk("mid_reg_write", 101, DW'(reg_write), DW'(0));
    chk("mid_write_register", 101, DW'(write_register), DW'(0));
    chk("mid_count", 101, DW'(count), DW'(0));
    chk("mid_in_ready", 101, DW'(in_ready), DW'(1));
    chk("mid_idle", 101, DW'(idle), DW'(1));
    chk("mid_fwd_hit_1", 101, DW'(fwd_hit_1), DW'(0));
    chk("mid_fwd_hit_2", 101, DW'(fwd_hit_2), DW'(0));
    for (int k = 0; k < 5; k++) begin
      step_clk();
      chk("post_rst_reg_write", 102 + k, DW'(reg_write), DW'(0));
      chk("post_rst_count", 102 + k, DW'(count), DW'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
